// File: rtl/branch_predict_resolve.sv
// branch_predict_resolve
// Execute-stage branch unit: resolves conditional branches, JAL and JALR with
// a registered outcome, and issues a one-cycle redirect pulse with a target PC
// on every mispredict or jump. A table of saturating direction counters (BHT)
// feeds a taken/not-taken prediction back to fetch.
// Optional feature macro: BRANCH_PREDICT_BHT_EN
//   defined   -> dynamic BHT is built; f_pred_taken comes from the table
//   undefined -> no table, static not-taken prediction (f_pred_taken = 0)
`timescale 1ns/1ps

module branch_predict_resolve #(
  parameter int XLEN      = 32,
  parameter int BHT_DEPTH = 64,
  parameter int CTR_BITS  = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] f_pc,
  output logic            f_pred_taken,
  input  logic            ex_valid,
  input  logic            ex_flush,
  input  logic [6:0]      ex_opcode,
  input  logic [2:0]      ex_funct3,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_rs1,
  input  logic [XLEN-1:0] ex_rs2,
  input  logic [XLEN-1:0] ex_imm,
  input  logic            ex_pred_taken,
  output logic            br_taken,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic [31:0]     br_count,
  output logic [31:0]     mispred_count
);

  localparam int          IDX_W      = $clog2(BHT_DEPTH);
  localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
  localparam logic [6:0]  OPC_JAL    = 7'b1101111;
  localparam logic [6:0]  OPC_JALR   = 7'b1100111;
  localparam logic [31:0] CNT_MAX    = 32'hFFFF_FFFF;
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(32'd4);

  // Decode / evaluation signals
  logic            live_s;
  logic            is_br_s;
  logic            is_jal_s;
  logic            is_jalr_s;
  logic            cond_s;
  logic            f3_ok_s;
  logic            pred_eff_s;
  logic [XLEN-1:0] br_tgt_s;
  logic [XLEN-1:0] fall_s;
  logic [XLEN-1:0] jalr_sum_s;
  logic [XLEN-1:0] jalr_tgt_s;

  // Registered state
  logic            br_taken_q, br_taken_d;
  logic            redirect_valid_q, redirect_valid_d;
  logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
  logic [31:0]     br_count_q, br_count_d;
  logic [31:0]     mispred_count_q, mispred_count_d;

  assign live_s     = ex_valid & ~ex_flush;
  assign is_br_s    = (ex_opcode == OPC_BRANCH);
  assign is_jal_s   = (ex_opcode == OPC_JAL);
  assign is_jalr_s  = (ex_opcode == OPC_JALR);
  assign br_tgt_s   = ex_pc + ex_imm;
  assign fall_s     = ex_pc + PC_STEP;
  assign jalr_sum_s = ex_rs1 + ex_imm;
  assign jalr_tgt_s = {jalr_sum_s[XLEN-1:1], 1'b0};

  // Evaluate the conditional-branch comparison selected by funct3
  always_comb begin
    cond_s  = 1'b0;
    f3_ok_s = 1'b1;
    case (ex_funct3)
      3'b000:  cond_s = (ex_rs1 == ex_rs2);
      3'b001:  cond_s = (ex_rs1 != ex_rs2);
      3'b100:  cond_s = ($signed(ex_rs1) <  $signed(ex_rs2));
      3'b101:  cond_s = ($signed(ex_rs1) >= $signed(ex_rs2));
      3'b110:  cond_s = (ex_rs1 <  ex_rs2);
      3'b111:  cond_s = (ex_rs1 >= ex_rs2);
      default: begin
        cond_s  = 1'b0;
        f3_ok_s = 1'b0;
      end
    endcase
  end

  // Next-state for the outcome, redirect and statistics registers
  always_comb begin
    br_taken_d       = 1'b0;
    redirect_valid_d = 1'b0;
    redirect_pc_d    = redirect_pc_q;
    br_count_d       = br_count_q;
    mispred_count_d  = mispred_count_q;
    if (live_s) begin
      if (is_br_s) begin
        br_taken_d = cond_s;
        br_count_d = (br_count_q == CNT_MAX) ? CNT_MAX : br_count_q + 32'd1;
        if (cond_s != pred_eff_s) begin
          redirect_valid_d = 1'b1;
          redirect_pc_d    = cond_s ? br_tgt_s : fall_s;
          mispred_count_d  = (mispred_count_q == CNT_MAX) ? CNT_MAX
                                                          : mispred_count_q + 32'd1;
        end else begin
          redirect_valid_d = 1'b0;
        end
      end else if (is_jal_s) begin
        // Predictor holds direction only, so jumps always redirect
        br_taken_d       = 1'b1;
        redirect_valid_d = 1'b1;
        redirect_pc_d    = br_tgt_s;
      end else if (is_jalr_s) begin
        br_taken_d       = 1'b1;
        redirect_valid_d = 1'b1;
        redirect_pc_d    = jalr_tgt_s;
      end else begin
        br_taken_d = 1'b0;
      end
    end else begin
      br_taken_d = 1'b0;
    end
  end

  // Outcome, redirect and statistics registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_taken_q       <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      br_count_q       <= 32'd0;
      mispred_count_q  <= 32'd0;
    end else begin
      br_taken_q       <= br_taken_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      br_count_q       <= br_count_d;
      mispred_count_q  <= mispred_count_d;
    end
  end

  assign br_taken       = br_taken_q;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign br_count       = br_count_q;
  assign mispred_count  = mispred_count_q;

`ifdef BRANCH_PREDICT_BHT_EN
  localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
  localparam logic [CTR_BITS-1:0] CTR_MIN  = '0;
  localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'((32'd1 << (CTR_BITS - 1)) - 32'd1);

  logic [CTR_BITS-1:0] bht_q [BHT_DEPTH];
  logic [IDX_W-1:0]    f_idx_s;
  logic [IDX_W-1:0]    ex_idx_s;
  logic [CTR_BITS-1:0] bht_cur_s;
  logic [CTR_BITS-1:0] bht_wdata_s;
  logic                bht_we_s;
  logic                unused_fpc_s;

  assign f_idx_s      = f_pc[IDX_W+1:2];
  assign ex_idx_s     = ex_pc[IDX_W+1:2];
  assign bht_cur_s    = bht_q[ex_idx_s];
  // Fetch reads the registered table, so a same-index update shows next cycle
  assign f_pred_taken = bht_q[f_idx_s][CTR_BITS-1];
  assign pred_eff_s   = ex_pred_taken;
  assign unused_fpc_s = ^{f_pc, ex_pc[1:0]};

  // Saturating counter update for a live conditional branch with valid funct3
  always_comb begin
    bht_we_s    = live_s & is_br_s & f3_ok_s;
    bht_wdata_s = bht_cur_s;
    if (cond_s) begin
      if (bht_cur_s == CTR_MAX) begin
        bht_wdata_s = bht_cur_s;
      end else begin
        bht_wdata_s = bht_cur_s + CTR_BITS'(32'd1);
      end
    end else begin
      if (bht_cur_s == CTR_MIN) begin
        bht_wdata_s = bht_cur_s;
      end else begin
        bht_wdata_s = bht_cur_s - CTR_BITS'(32'd1);
      end
    end
  end

  // Direction-counter table, reset to weakly not-taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_DEPTH; i++) begin
        bht_q[i] <= CTR_INIT;
      end
    end else if (bht_we_s) begin
      bht_q[ex_idx_s] <= bht_wdata_s;
    end
  end
`else
  logic unused_pred_s;

  // Static not-taken: every taken conditional branch is a mispredict
  assign f_pred_taken  = 1'b0;
  assign pred_eff_s    = 1'b0;
  assign unused_pred_s = ^{f_pc, ex_pred_taken, f3_ok_s};
`endif

endmodule
